// File: rtl/niosv_pio_pkg.sv
// Shared constants for the Nios V input PIO: register map and edge-type encodings.
package niosv_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic edge_sel(input int edge_type, input logic prev_v, input logic cur_v);
    logic hit_v;
    hit_v = 1'b0;
    case (edge_type)
      EDGE_RISING:  hit_v = cur_v & ~prev_v;
      EDGE_FALLING: hit_v = prev_v & ~cur_v;
      default:      hit_v = prev_v ^ cur_v;
    endcase
    return hit_v;
  endfunction

endpackage

// File: rtl/niosv_pio_debounce.sv
// One input channel: priming from the first valid synchronised sample, optional
// debounce filter, and edge detection on the filtered level.
module niosv_pio_debounce
  import niosv_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_vld,
  input  logic sync_bit,
  output logic stable,
  output logic edge_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic stable_r, stable_s;
  logic stable_q_r, stable_q_s;
  logic primed_r, primed_s;

  // Next-state for priming, debounce counter and accepted level
  always_comb begin
    cnt_s    = cnt_r;
    stable_s = stable_r;
    primed_s = primed_r;
    if (!primed_r) begin
      cnt_s = '0;
      if (sync_vld) begin
        stable_s = sync_bit;
        primed_s = 1'b1;
      end else begin
        stable_s = stable_r;
      end
    end else if (DEBOUNCE_CYCLES == 0) begin
      stable_s = sync_bit;
    end else if (sync_bit == stable_r) begin
      cnt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      stable_s = sync_bit;
      cnt_s    = '0;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
    // The priming sample becomes the reference too, so it never looks like an edge.
    stable_q_s = primed_r ? stable_r : stable_s;
  end

  // Channel state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= '0;
      stable_r   <= 1'b0;
      stable_q_r <= 1'b0;
      primed_r   <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      stable_r   <= stable_s;
      stable_q_r <= stable_q_s;
      primed_r   <= primed_s;
    end
  end

  assign stable     = stable_r;
  assign edge_pulse = primed_r & edge_sel(EDGE_TYPE, stable_q_r, stable_r);

endmodule

// File: rtl/niosv_pio_in_irq.sv
// Avalon-MM input PIO with per-channel synchroniser/debounce, W1C edge capture
// and a maskable level interrupt.
module niosv_pio_in_irq
  import niosv_pio_pkg::*;
#(
  parameter int          WIDTH           = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] RESET_IRQMASK   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_r, sync2_r;
  logic [1:0]       sync_vld_r;
  logic [WIDTH-1:0] stable_s, edge_s;
  logic [WIDTH-1:0] irqmask_r, irqmask_s;
  logic [WIDTH-1:0] edgecap_r, edgecap_s;
  logic [WIDTH-1:0] clr_s;
  logic [31:0]      readdata_r, rdata_s;
  logic             irq_r;
  logic             wr_s;
  logic             unused_s;

  // Two-flop synchroniser plus a marker for when its output carries real samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r    <= '0;
      sync2_r    <= '0;
      sync_vld_r <= 2'b00;
    end else begin
      sync1_r    <= in_port;
      sync2_r    <= sync1_r;
      sync_vld_r <= {sync_vld_r[0], 1'b1};
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    niosv_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .sync_vld  (sync_vld_r[1]),
      .sync_bit  (sync2_r[g]),
      .stable    (stable_s[g]),
      .edge_pulse(edge_s[g])
    );
  end

  assign wr_s     = chipselect & ~write_n;
  assign unused_s = ^writedata;

  // Register writes, edge capture and read mux
  always_comb begin
    irqmask_s = irqmask_r;
    clr_s     = '0;
    if (wr_s && (address == PIO_ADDR_IRQMASK)) begin
      irqmask_s = writedata[WIDTH-1:0];
    end else if (wr_s && (address == PIO_ADDR_EDGE)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      irqmask_s = irqmask_r;
    end
    // OR-ing the new edge after the clear keeps an edge that lands with a W1C.
    edgecap_s = (edgecap_r & ~clr_s) | edge_s;

    rdata_s = '0;
    case (address)
      PIO_ADDR_DATA:    rdata_s[WIDTH-1:0] = stable_s;
      PIO_ADDR_IRQMASK: rdata_s[WIDTH-1:0] = irqmask_r;
      PIO_ADDR_EDGE:    rdata_s[WIDTH-1:0] = edgecap_r;
      default:          rdata_s = '0;
    endcase
  end

  // Control registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_r  <= RESET_IRQMASK[WIDTH-1:0];
      edgecap_r  <= '0;
      readdata_r <= 32'h0000_0000;
      irq_r      <= 1'b0;
    end else begin
      irqmask_r  <= irqmask_s;
      edgecap_r  <= edgecap_s;
      readdata_r <= rdata_s;
      irq_r      <= |(edgecap_r & irqmask_r);
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule
